rggen_axi4lite_initiator: RTL
=============================

// Module: rggen_axi4lite_initiator
// PURPOSE
//  Single-outstanding AXI4-Lite master (initiator) driving rggen register blocks such as block_1.
//  - Accepts one read/write command on a valid/ready command port.
//  - Runs the matching AXI4-Lite transaction.
//  - Returns read data and status on a valid/ready response port.
//  - Used by testbench sequencers and on-chip config controllers.
// PARAMETERS
//  ADDRESS_WIDTH   7     byte address width of AW/AR and command address
//  BUS_WIDTH       32    data width, 32 or 64; strobe width = BUS_WIDTH/8
//  TIMEOUT_CYCLES  256   response-wait limit, >=2; used only with the timeout macro
// PORTS
//  i_clk              in   1       clock
//  i_rst_n            in   1       synchronous active-low reset
//  i_cmd_valid/o_cmd_ready in/out 1/1  command handshake
//  i_cmd_write        in   1       1=write, 0=read
//  i_cmd_address      in   AW      byte address; low log2(BUS_WIDTH/8) bits forwarded unchanged
//  i_cmd_write_data   in   BW      write data
//  i_cmd_strobe       in   BW/8    write byte strobes
//  o_rsp_valid/i_rsp_ready out/in 1/1  response handshake
//  o_rsp_read_data    out  BW      RDATA for reads, 0 for writes
//  o_rsp_status       out  2       00 OKAY, 10 SLVERR, 11 DECERR, 01 TIMEOUT
//  o_awvalid,i_awready,o_awaddr[AW],o_awprot[3]  AW channel
//  o_wvalid,i_wready,o_wdata[BW],o_wstrb[BW/8]   W channel
//  i_bvalid,o_bready,i_bresp[2]                  B channel
//  o_arvalid,i_arready,o_araddr[AW],o_arprot[3]  AR channel
//  i_rvalid,o_rready,i_rdata[BW],i_rresp[2]      R channel
// BEHAVIOUR
//  - Reset (i_rst_n low at posedge): state IDLE, all valid/ready outputs 0, data/addr/status regs 0.
//  - Reset mid-transaction abandons the transaction. Downstream slaves share this reset.
//  - States: IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, RESP (+DRAIN with macro).
//  - IDLE: o_cmd_ready=1, no other handshake outputs asserted.
//    On cmd handshake, register addr/data/strobe/write.
//    Next cycle: WR_REQ with o_awvalid=o_wvalid=1, or RD_REQ with o_arvalid=1.
//  - Minimum latency: cmd accept -> o_awvalid/o_arvalid = 1 cycle.
//  - o_awprot = o_arprot = 3'b000.
//  - WR_REQ: AW and W complete independently. Each valid drops in the cycle after its own handshake.
//    Same-cycle handshakes on both are legal.
//    Go to WR_RSP once both are done. o_bready=1 only in WR_RSP.
//  - RD_REQ: o_arvalid held until i_arready; then RD_RSP with o_rready=1.
//  - Never withdraw a valid before its handshake; payload stable while valid.
//  - WR_RSP/RD_RSP: on B/R handshake, capture resp (+rdata); go to RESP.
//    o_rsp_status = bresp/rresp verbatim (EXOKAY 01 never expected).
//  - RESP: o_rsp_valid=1, data/status held until i_rsp_ready; then IDLE.
//    Back-to-back throughput: 1 cmd per >=4 cycles. o_cmd_ready=0 outside IDLE.
//  - Early B or R (before request handshake) is not sampled: o_bready/o_rready are 0 then.
// CONFIGURATION
//  - Macro RGGEN_AXI4LITE_INITIATOR_TIMEOUT_EN.
//  - Defined:
//    - Counter clears on entry to WR_RSP/RD_RSP and increments each cycle there.
//    - At count == TIMEOUT_CYCLES-1 with no B/R handshake, go to RESP with status 01 and rdata 0.
//    - Then enter DRAIN, which keeps o_bready/o_rready=1 and discards the late response.
//    - DRAIN blocks new commands (o_cmd_ready=0) until that response is consumed or reset.
//  - Undefined: no counter, no DRAIN; response wait is unbounded; status 01 never produced.
// TESTING
//  1. Write 0x00 data 0xA5A5_5A5A strb 0xF, slave readies immediately, BRESP=00 -> AW/W 1 cycle each, rsp status 00, data 0.
//  2. Read 0x04, ARREADY after 3 cycles, RDATA=0x1234_5678 RRESP=00 -> o_arvalid held 4 cycles, rsp data 0x1234_5678.
//  3. Write with WREADY 2 cycles before AWREADY -> o_wvalid drops first, o_bready only after both handshakes.
//  4. Read returning RRESP=10; i_rsp_ready low 5 cycles -> o_rsp_valid/status 10 held stable 5 cycles, o_cmd_ready=0.
//  5. Reset pulse during WR_RSP -> next cycle all valids/readies 0, o_cmd_ready=1.
//  6. TIMEOUT_EN, TIMEOUT_CYCLES=8, no BVALID -> status 01 after 8 wait cycles.
//     BVALID at cycle 20 is drained, then next cmd is accepted.

Source files
------------

// File: rtl/rggen_axi4lite_initiator.sv
// rtl/rggen_axi4lite_initiator.sv - single-outstanding AXI4-Lite initiator with command/response ports
// Optional response timeout and drain: define RGGEN_AXI4LITE_INITIATOR_TIMEOUT_EN.
module rggen_axi4lite_initiator #(
    parameter int ADDRESS_WIDTH  = 7,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic                     i_cmd_write,
    input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
    input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
    input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
    output logic [1:0]               o_rsp_status,
    output logic                     o_awvalid,
    input  logic                     i_awready,
    output logic [ADDRESS_WIDTH-1:0] o_awaddr,
    output logic [2:0]               o_awprot,
    output logic                     o_wvalid,
    input  logic                     i_wready,
    output logic [BUS_WIDTH-1:0]     o_wdata,
    output logic [BUS_WIDTH/8-1:0]   o_wstrb,
    input  logic                     i_bvalid,
    output logic                     o_bready,
    input  logic [1:0]               i_bresp,
    output logic                     o_arvalid,
    input  logic                     i_arready,
    output logic [ADDRESS_WIDTH-1:0] o_araddr,
    output logic [2:0]               o_arprot,
    input  logic                     i_rvalid,
    output logic                     o_rready,
    input  logic [BUS_WIDTH-1:0]     i_rdata,
    input  logic [1:0]               i_rresp
);
    localparam int STRB_W = BUS_WIDTH / 8;

    if (!(BUS_WIDTH == 32 || BUS_WIDTH == 64) || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("rggen_axi4lite_initiator: BUS_WIDTH must be 32 or 64 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE, ST_WR_REQ, ST_WR_RSP, ST_RD_REQ, ST_RD_RSP, ST_RESP, ST_DRAIN
    } state_t;

    state_t                   state_q, state_d;
    logic                     write_q, write_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_WIDTH-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]        strb_q, strb_d;
    logic                     aw_done_q, aw_done_d;
    logic                     w_done_q, w_done_d;
    logic [BUS_WIDTH-1:0]     rdata_q, rdata_d;
    logic [1:0]               status_q, status_d;
`ifdef RGGEN_AXI4LITE_INITIATOR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     timed_out_q, timed_out_d;
`endif

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        status_d  = status_q;
`ifdef RGGEN_AXI4LITE_INITIATOR_TIMEOUT_EN
        cnt_d       = cnt_q;
        timed_out_d = timed_out_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    write_d   = i_cmd_write;
                    addr_d    = i_cmd_address;
                    wdata_d   = i_cmd_write_data;
                    strb_d    = i_cmd_strobe;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = i_cmd_write ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                // AW and W retire independently; the valid of a finished channel is masked by its done flag
                aw_done_d = aw_done_q | i_awready;
                w_done_d  = w_done_q | i_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WR_RSP;
`ifdef RGGEN_AXI4LITE_INITIATOR_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_WR_RSP: begin
                if (i_bvalid) begin
                    status_d = i_bresp;
                    rdata_d  = '0;
                    state_d  = ST_RESP;
                end
`ifdef RGGEN_AXI4LITE_INITIATOR_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    status_d    = 2'b01;
                    rdata_d     = '0;
                    timed_out_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_RD_REQ: begin
                if (i_arready) begin
                    state_d = ST_RD_RSP;
`ifdef RGGEN_AXI4LITE_INITIATOR_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_RD_RSP: begin
                if (i_rvalid) begin
                    status_d = i_rresp;
                    rdata_d  = i_rdata;
                    state_d  = ST_RESP;
                end
`ifdef RGGEN_AXI4LITE_INITIATOR_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    status_d    = 2'b01;
                    rdata_d     = '0;
                    timed_out_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
`ifdef RGGEN_AXI4LITE_INITIATOR_TIMEOUT_EN
                    state_d = timed_out_q ? ST_DRAIN : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef RGGEN_AXI4LITE_INITIATOR_TIMEOUT_EN
            ST_DRAIN: begin
                // the late response still belongs to the abandoned transaction and is dropped
                if (write_q ? i_bvalid : i_rvalid) begin
                    timed_out_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            status_q  <= 2'b00;
`ifdef RGGEN_AXI4LITE_INITIATOR_TIMEOUT_EN
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            status_q  <= status_d;
`ifdef RGGEN_AXI4LITE_INITIATOR_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timed_out_q <= timed_out_d;
`endif
        end
    end

    assign o_cmd_ready     = (state_q == ST_IDLE);
    assign o_rsp_valid     = (state_q == ST_RESP);
    assign o_rsp_read_data = rdata_q;
    assign o_rsp_status    = status_q;
    assign o_awvalid       = (state_q == ST_WR_REQ) && !aw_done_q;
    assign o_wvalid        = (state_q == ST_WR_REQ) && !w_done_q;
    assign o_awaddr        = addr_q;
    assign o_awprot        = 3'b000;
    assign o_wdata         = wdata_q;
    assign o_wstrb         = strb_q;
    assign o_arvalid       = (state_q == ST_RD_REQ);
    assign o_araddr        = addr_q;
    assign o_arprot        = 3'b000;
`ifdef RGGEN_AXI4LITE_INITIATOR_TIMEOUT_EN
    assign o_bready = (state_q == ST_WR_RSP) || ((state_q == ST_DRAIN) && write_q);
    assign o_rready = (state_q == ST_RD_RSP) || ((state_q == ST_DRAIN) && !write_q);
`else
    assign o_bready = (state_q == ST_WR_RSP);
    assign o_rready = (state_q == ST_RD_RSP);
`endif
endmodule
